// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, FSM states
// and the store byte-lane helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] wd;
    } store_lanes_t;

    // Byte-lane mask plus lane-replicated data; memory picks the right lanes via we.
    function automatic store_lanes_t store_lanes(input logic [2:0]  funct3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] wdata);
        store_lanes_t s;
        s.we = 4'b0000;
        s.wd = 32'h0;
        case (funct3)
            F3_B: begin
                s.we = 4'b0001 << off;
                s.wd = {4{wdata[7:0]}};
            end
            F3_H: begin
                s.we = 4'b0011 << off;
                s.wd = {2{wdata[15:0]}};
            end
            F3_W: begin
                s.we = 4'b1111;
                s.wd = wdata;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a memory word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_mem_rd,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_mem_rd[{i_off, 3'b000} +: 8];
        w_half   = i_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        o_result = 32'h0;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'h0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'h0, w_half};
            F3_W:    o_result = i_mem_rd;
            default: o_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// RV32I load/store sequencer: accepts one access per handshake, drives a synchronous-read
// word memory, and returns an extended load result or an error pulse.
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_rd
);

    state_e       r_state;
    state_e       w_state_d;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [1:0]   r_off;
    logic [31:0]  r_wdata;
    logic         r_err;
    logic [31:0]  r_rdata;
    logic [31:0]  r_mem_addr;

    logic         w_accept;
    logic         w_err;
    logic         w_f3_legal;
    logic [31:0]  w_word_idx;
    logic [31:0]  w_load_result;
    store_lanes_t w_lanes;

    assign w_accept   = (r_state == IDLE) && i_req_valid;
    assign w_word_idx = {2'b00, i_req_addr[31:2]};

    always_comb begin
        if (i_req_we) begin
            w_f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) ||
                         (i_req_funct3 == F3_W);
        end else begin
            w_f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) ||
                         (i_req_funct3 == F3_W) || (i_req_funct3 == F3_BU) ||
                         (i_req_funct3 == F3_HU);
        end
        w_err = !w_f3_legal ||
                (((i_req_funct3 == F3_H) || (i_req_funct3 == F3_HU)) && i_req_addr[0]) ||
                ((i_req_funct3 == F3_W) && (i_req_addr[1:0] != 2'b00)) ||
                (w_word_idx >= 32'(MEM_WORDS));
    end

    lsu_load_align u_load_align (
        .i_mem_rd (i_mem_rd),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_result (w_load_result)
    );

    assign w_lanes = store_lanes(r_funct3, r_off, r_wdata);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_state_d = w_err ? RESP : ISSUE;
            ISSUE:   w_state_d = r_we ? RESP : WAIT;
            WAIT:    w_state_d = RESP;
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Rejected accesses never update mem_addr, so memory sees no trace of them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_rdata    <= 32'h0;
            r_mem_addr <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_off    <= i_req_addr[1:0];
                r_wdata  <= i_req_wdata;
                r_err    <= w_err;
                r_rdata  <= 32'h0;
                if (!w_err) begin
                    r_mem_addr <= w_word_idx;
                end
            end
            if (r_state == WAIT) begin
                r_rdata <= w_load_result;
            end
        end
    end

    // Reset gates the write strobe combinationally so a store caught in ISSUE is dropped.
    always_comb begin
        o_req_ready  = (r_state == IDLE) && !i_rst;
        o_resp_valid = (r_state == RESP) && !i_rst;
        o_resp_error = (r_state == RESP) && r_err && !i_rst;
        o_resp_rdata = r_rdata;
        o_mem_addr   = r_mem_addr;
        o_mem_we     = 4'b0000;
        o_mem_wd     = 32'h0;
        if ((r_state == ISSUE) && r_we && !i_rst) begin
            o_mem_we = w_lanes.we;
            o_mem_wd = w_lanes.wd;
        end
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer with a small synchronous-read memory model.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'h0;

    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_sequencer #(.MEM_WORDS(65536)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_error (resp_error),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wd     (mem_wd),
        .i_mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        mem_rd <= mem[mem_addr[9:0]];
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_addr[9:0]][8*i +: 8] <= mem_wd[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check({tag, ".ready_timeout"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_we, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_wd);
        int          lat;
        logic [3:0]  issue_we;
        logic [31:0] issue_addr;
        logic [31:0] issue_wd;
        logic [3:0]  we_seen;
        @(negedge clk);
        wait_ready(tag);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        lat        = 1;
        issue_we   = mem_we;
        issue_addr = mem_addr;
        issue_wd   = mem_wd;
        we_seen    = mem_we;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            we_seen |= mem_we;
        end
        if (!resp_valid) check({tag, ".resp_timeout"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, {31'b0, resp_error}, {31'b0, exp_err});
        if (exp_err) begin
            check({tag, ".no_write"}, {28'b0, we_seen}, 32'h0);
        end else begin
            check({tag, ".mem_we"}, {28'b0, issue_we}, {28'b0, exp_we});
            check({tag, ".mem_addr"}, issue_addr, exp_maddr);
            if (we) check({tag, ".mem_wd"}, issue_wd, exp_wd);
        end
        @(negedge clk);
        check({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [2:0]  b_f3   [3];
        logic [31:0] b_addr [3];
        logic [31:0] b_exp  [3];
        int          t_prev;
        int          guard;

        b_f3   = '{3'b010, 3'b100, 3'b101};
        b_addr = '{32'h10, 32'h13, 32'h22};
        b_exp  = '{32'hA5ADBEEF, 32'h000000A5, 32'h00008001};

        repeat (2) @(negedge clk);
        check("rst.ready", {31'b0, req_ready}, 32'd0);
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_we", {28'b0, mem_we}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", {31'b0, req_ready}, 32'd1);

        txn("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 4'hF, 32'd4, 32'hDEADBEEF);
        txn("lw",  1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'h0, 32'd4, 32'h0);
        txn("sb",  1'b1, 3'b000, 32'h13, 32'hA5, 2, 32'h0, 1'b0, 4'h8, 32'd4, 32'hA5A5A5A5);
        txn("lb",  1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFFA5, 1'b0, 4'h0, 32'd4, 32'h0);
        txn("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h000000A5, 1'b0, 4'h0, 32'd4, 32'h0);
        txn("sh",  1'b1, 3'b001, 32'h22, 32'h8001, 2, 32'h0, 1'b0, 4'hC, 32'd8, 32'h80018001);
        txn("lh",  1'b0, 3'b001, 32'h22, 32'h0, 3, 32'hFFFF8001, 1'b0, 4'h0, 32'd8, 32'h0);
        txn("lhu", 1'b0, 3'b101, 32'h22, 32'h0, 3, 32'h00008001, 1'b0, 4'h0, 32'd8, 32'h0);

        txn("err_lw6",   1'b0, 3'b010, 32'h06, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        txn("err_sh1",   1'b1, 3'b001, 32'h01, 32'h1234, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        txn("err_ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        txn("err_st100", 1'b1, 3'b100, 32'h10, 32'h55, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        txn("err_range", 1'b1, 3'b010, 32'h00040000, 32'h1, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);

        txn("sw40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 2, 32'h0, 1'b0, 4'hF, 32'd16, 32'hCAFEF00D);
        @(negedge clk);
        wait_ready("rst_store");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h11111111;
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_issue.mem_we", {28'b0, mem_we}, 32'h0);
        @(negedge clk);
        check("rst_issue.ready", {31'b0, req_ready}, 32'd0);
        check("rst_issue.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_issue.resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_issue.rdata", resp_rdata, 32'h0);
        check("rst_issue.mem_addr", mem_addr, 32'h0);
        check("rst_issue.mem_wd", mem_wd, 32'h0);
        check("rst_issue.mem", mem[16], 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        check("rst_issue.ready_after", {31'b0, req_ready}, 32'd1);
        txn("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'hCAFEF00D, 1'b0, 4'h0, 32'd16, 32'h0);

        // Back-to-back loads with valid never dropped.
        @(negedge clk);
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_ready("b2b");
            if (k > 0) check("b2b.interval", 32'(cyc - t_prev), 32'd4);
            t_prev     = cyc;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = b_f3[k];
            req_addr   = b_addr[k];
            @(negedge clk);
            guard = 0;
            while (!resp_valid && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            check("b2b.rdata", resp_rdata, b_exp[k]);
            @(negedge clk);
        end
        req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
